mem_responder: RTL and testbench

- Single-port memory responder on the data/instruction side of the RV32I multicycle core; the memory end of the core's request/response bus.
- Accepts one load/store request at a time over a valid/ready handshake and performs it on an internal word-organised array.
- Returns load data (sign- or zero-extended per funct3) after a fixed, parameterised latency.
- Flags misaligned, out-of-range and illegal-funct3 accesses.

---
 rtl/mem_responder.sv | 157 +++++++++++++++
 tb/tb_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port load/store responder: one request at a time over valid/ready,
// word-organised array, fixed response latency, error flagging for illegal
// funct3, misalignment and out-of-range addresses.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_we;
    logic [2:0]    acc_f3;
    logic          f3_ok;
    logic          misaligned;
    logic          out_of_range;
    logic          err_d;
    logic [IW-1:0] widx;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [31:0]   ld_data;
    logic [31:0]   rdata_d;
    logic [3:0]    be;
    logic [31:0]   wlanes;

    // Ready only in IDLE and never while reset is held, so it drops with reset.
    assign req_ready  = reset && (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign accept = req_valid && req_ready;
    // With LATENCY=1 the access commits on the accept edge itself, so the
    // live request inputs feed the access path; otherwise the latched copy.
    assign commit = reset && (((state_q == S_IDLE) && accept && (LATENCY == 1)) ||
                              ((state_q == S_BUSY) && (cnt_q == 4'd1)));

    assign acc_addr  = (state_q == S_IDLE) ? req_addr   : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? req_wdata  : wdata_q;
    assign acc_we    = (state_q == S_IDLE) ? req_we     : we_q;
    assign acc_f3    = (state_q == S_IDLE) ? req_funct3 : f3_q;

    // Decode the access: error checks, load extraction and store lane enables.
    always_comb begin
        if (acc_we) f3_ok = acc_f3 inside {3'b000, 3'b001, 3'b010};
        else        f3_ok = acc_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misaligned   = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                       ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
        out_of_range = {2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS);
        err_d        = !f3_ok || misaligned || out_of_range;

        widx    = acc_addr[IW+1:2];
        word    = mem[widx];
        shifted = word >> {acc_addr[1:0], 3'b000};

        case (acc_f3)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  ld_data = word;
            3'b100:  ld_data = {24'd0, shifted[7:0]};
            3'b101:  ld_data = {16'd0, shifted[15:0]};
            default: ld_data = 32'd0;
        endcase
        rdata_d = (err_d || acc_we) ? 32'd0 : ld_data;

        case (acc_f3[1:0])
            2'b00:   begin be = 4'b0001 << acc_addr[1:0];        wlanes = {4{acc_wdata[7:0]}};  end
            2'b01:   begin be = 4'b0011 << {acc_addr[1], 1'b0};  wlanes = {2{acc_wdata[15:0]}}; end
            default: begin be = 4'b1111;                         wlanes = acc_wdata;            end
        endcase
    end

    // Array write on the commit edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && acc_we && !err_d) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    // Request/response FSM with latency counter and registered response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        if (LATENCY == 1) begin
                            state_q <= S_RESP;
                            rdata_q <= rdata_d;
                            err_q   <= err_d;
                        end else begin
                            state_q <= S_BUSY;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                        rdata_q <= rdata_d;
                        err_q   <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder against a byte-addressed reference model.
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mb [4*DEPTH];

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte memory, size = 1<<funct3[1:0] bytes, little-endian.
    function automatic void model(input logic [31:0] a, input logic we, input logic [2:0] f3,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int nb;
        bit legal;
        logic [31:0] v;
        rd    = 32'd0;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        nb    = 1 << f3[1:0];
        err   = !legal || ((a % nb) != 0) || ((a / 4) >= DEPTH);
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mb[a + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v = v | (32'(mb[a + i]) << (8*i));
                if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
                rd = v;
            end
        end
    endfunction

    task automatic do_req(input logic [31:0] a, input logic we, input logic [2:0] f3,
                          input logic [31:0] wd, input int hold, input string tag,
                          output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        logic        eer;
        int          n;
        model(a, we, f3, wd, erd, eer);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk($sformatf("%s.rdy", tag), req_ready, 1);
        req_valid  = 1'b1;
        req_addr   = a;
        req_we     = we;
        req_funct3 = f3;
        req_wdata  = wd;
        resp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        // Junk on the request side while busy must be ignored.
        req_valid  = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_wdata  = $urandom;
        n = 1;
        while (!resp_valid && n < 20) begin
            chk($sformatf("%s.busy_rdy", tag), req_ready, 0);
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s.lat", tag), n, LAT);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk($sformatf("%s.hold", tag), {resp_valid, req_ready, resp_err, resp_rdata},
                {1'b1, 1'b0, er, rd});
        end
        chk($sformatf("%s.rdata", tag), resp_rdata, erd);
        chk($sformatf("%s.err", tag), resp_err, eer);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk($sformatf("%s.done", tag), {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        #1;
        chk("rst.outs", {req_ready, resp_valid, resp_err, resp_rdata}, 35'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst.idle", {req_ready, resp_valid}, 2'b10);
        @(negedge clk);

        // Known contents for the region the random phase touches.
        for (int w = 0; w < 64; w++) do_req(32'(4*w), 1'b1, 3'd2, $urandom, 0, "init", rd, er);

        do_req(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 0, "sw10", rd, er);
        do_req(32'h10, 1'b0, 3'd2, 32'd0, 0, "lw10", rd, er);
        chk("lw10.const", {er, rd}, {1'b0, 32'hDEADBEEF});
        do_req(32'h13, 1'b1, 3'd0, 32'h00000080, 0, "sb13", rd, er);
        chk("sb13.const", {er, rd}, 33'd0);
        do_req(32'h13, 1'b0, 3'd0, 32'd0, 1, "lb13", rd, er);
        chk("lb13.const", rd, 32'hFFFFFF80);
        do_req(32'h13, 1'b0, 3'd4, 32'd0, 0, "lbu13", rd, er);
        chk("lbu13.const", rd, 32'h00000080);
        do_req(32'h10, 1'b0, 3'd2, 32'd0, 0, "lw10b", rd, er);
        chk("lw10b.const", rd, 32'h80ADBEEF);
        do_req(32'h12, 1'b0, 3'd5, 32'd0, 0, "lhu12", rd, er);
        chk("lhu12.const", rd, 32'h000080AD);
        do_req(32'h11, 1'b0, 3'd1, 32'd0, 0, "lh11", rd, er);
        chk("lh11.const", {er, rd}, {1'b1, 32'd0});
        do_req(32'h12, 1'b1, 3'd2, 32'h12345678, 0, "sw12", rd, er);
        chk("sw12.const", er, 1);
        do_req(32'h10, 1'b0, 3'd2, 32'd0, 0, "lw10c", rd, er);
        chk("lw10c.const", rd, 32'h80ADBEEF);
        do_req(32'h10, 1'b0, 3'd3, 32'd0, 0, "f3_011", rd, er);
        chk("f3_011.const", {er, rd}, {1'b1, 32'd0});
        do_req(32'h1000, 1'b0, 3'd2, 32'd0, 0, "lw1000", rd, er);
        chk("lw1000.const", {er, rd}, {1'b1, 32'd0});
        do_req(32'hFFC, 1'b1, 3'd2, 32'h0BADF00D, 0, "swffc", rd, er);
        do_req(32'hFFC, 1'b0, 3'd2, 32'd0, 5, "lwffc", rd, er);
        chk("lwffc.const", {er, rd}, {1'b0, 32'h0BADF00D});

        // Randomised traffic checked against the model.
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 15) == 0) a = 32'h1000 | $urandom;
            else                            a = 32'($urandom_range(0, 255));
            do_req(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 3), "rnd", rd, er);
        end

        // Reset during BUSY drops a pending store and clears outputs at once.
        do_req(32'h20, 1'b1, 3'd2, 32'h11111111, 0, "sw20", rd, er);
        do_req(32'h20, 1'b0, 3'd2, 32'd0, 0, "lw20", rd, er);
        chk("lw20.const", rd, 32'h11111111);
        req_valid = 1'b1; req_addr = 32'h20; req_we = 1'b1; req_funct3 = 3'd2;
        req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rbusy.pre", {resp_valid, req_ready}, 2'b00);
        #1 reset = 1'b0;
        #1;
        chk("rbusy.clr", {req_ready, resp_valid, resp_err, resp_rdata}, 35'd0);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rbusy.idle", {resp_valid, req_ready}, 2'b01);
        do_req(32'h20, 1'b0, 3'd2, 32'd0, 0, "lw20b", rd, er);
        chk("lw20b.const", rd, 32'h11111111);

        // Reset during RESP withdraws the response.
        req_valid = 1'b1; req_addr = 32'h10; req_we = 1'b0; req_funct3 = 3'd2;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rresp.pre", resp_valid, 1);
        #1 reset = 1'b0;
        #1;
        chk("rresp.clr", {req_ready, resp_valid, resp_err, resp_rdata}, 35'd0);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rresp.idle", {resp_valid, req_ready}, 2'b01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
